// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass across all
// write ports and a post-reset clear sequencer that gates the file until done.
module regfile_mp #(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR*DW-1:0] wdata,
    input  logic [NRD-1:0]    re,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic              ready
);

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic [DW-1:0]     regs_q [DEPTH];
    logic [NWR-1:0]    wcommit;
    logic [AW-1:0]     ra;
    logic [DW-1:0]     rval;

    // Clear sequencer next state: walk every index once, then enter RUN.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        if (state_q == StInit) begin
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d = StRun;
                ready_d = 1'b1;
            end else begin
                clr_idx_d = clr_idx_q + 1'b1;
            end
        end
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StInit;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    // Per-port write qualification; only these writes commit or bypass.
    always_comb begin
        wcommit = '0;
        for (int k = 0; k < NWR; k++) begin
            wcommit[k] = !rst && (state_q == StRun) && we[k]
                       && (32'(waddr[k*AW +: AW]) < DEPTH)
                       && !((ZERO_REG != 0) && (waddr[k*AW +: AW] == '0));
        end
    end

    // Storage: clear one entry per cycle in INIT, else apply committed writes.
    // Ascending port loop lets the highest-index port win on a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StInit) begin
                regs_q[clr_idx_q] <= '0;
            end else begin
                for (int k = 0; k < NWR; k++) begin
                    if (wcommit[k]) begin
                        regs_q[waddr[k*AW +: AW]] <= wdata[k*DW +: DW];
                    end
                end
            end
        end
    end

    // Read ports: zero unless enabled, usable and in range; bypass wins over array.
    always_comb begin
        rdata = '0;
        ra    = '0;
        rval  = '0;
        for (int i = 0; i < NRD; i++) begin
            ra   = raddr[i*AW +: AW];
            rval = '0;
            if (!rst && ready_q && re[i] && (32'(ra) < DEPTH)
                && !((ZERO_REG != 0) && (ra == '0))) begin
                rval = regs_q[ra];
                for (int k = 0; k < NWR; k++) begin
                    if (wcommit[k] && (waddr[k*AW +: AW] == ra)) begin
                        rval = wdata[k*DW +: DW];
                    end
                end
            end
            rdata[i*DW +: DW] = rval;
        end
    end

    assign ready = ready_q;

endmodule
